// File: rtl/vga_scan_engine.sv
// rtl/vga_scan_engine.sv - programmable VGA timing and double-buffered framebuffer scan-out
// Optional colour-bar source enabled by defining VGA_TESTPAT_EN.
module vga_scan_engine #(
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 24,
  parameter int H_SYNC      = 72,
  parameter int H_BP        = 128,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 22,
  parameter bit H_POL       = 1'b1,
  parameter bit V_POL       = 1'b1,
  parameter int SCALE_SHIFT = 3,
  parameter int PIX_W       = 8,
  parameter int RD_LAT      = 1,
  parameter int ADDR_W      = 14
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SWAP_REQ,
`ifdef VGA_TESTPAT_EN
  input  logic              TESTPAT,
`endif
  input  logic [PIX_W-1:0]  RD_DATA,
  output logic              SWAP_ACK,
  output logic              BUF_SEL,
  output logic [ADDR_W:0]   RD_ADDR,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic              DE,
  output logic [PIX_W-1:0]  PIXEL,
  output logic              FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
  localparam int D       = RD_LAT + 2;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam logic [VW-1:0] SCALE_MASK = VW'((1 << SCALE_SHIFT) - 1);

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  logic [HW:0]       hx;
  logic [VW:0]       vx;
  logic              h_last, v_last, frame_end;
  logic              active, hs, vs, fs;
  logic              pending;
  logic [ADDR_W-1:0] line_base;
  logic [D-1:0]      act_p, hs_p, vs_p, fs_p;
  logic [PIX_W-1:0]  pix_src;

  assign hx        = {1'b0, h};
  assign vx        = {1'b0, v};
  assign h_last    = (h == HW'(H_TOTAL - 1));
  assign v_last    = (v == VW'(V_TOTAL - 1));
  assign frame_end = h_last && v_last;

  always_ff @(posedge CLK) begin
    if (RST) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  always_comb begin
    active = (hx < (HW+1)'(H_ACTIVE)) && (vx < (VW+1)'(V_ACTIVE));
    hs = ((hx >= (HW+1)'(H_ACTIVE + H_FP)) && (hx < (HW+1)'(H_ACTIVE + H_FP + H_SYNC)))
         ? H_POL : ~H_POL;
    vs = ((vx >= (VW+1)'(V_ACTIVE + V_FP)) && (vx < (VW+1)'(V_ACTIVE + V_FP + V_SYNC)))
         ? V_POL : ~V_POL;
    fs = (h == '0) && (v == '0);
  end

  // Row start address advances by one framebuffer line each time v enters a new scaled row.
  always_ff @(posedge CLK) begin
    if (RST) begin
      line_base <= '0;
    end else if (h_last) begin
      if (v_last)
        line_base <= '0;
      else if (((v + VW'(1)) & SCALE_MASK) == '0)
        line_base <= line_base + ADDR_W'(FB_W);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) RD_ADDR <= '0;
    else     RD_ADDR <= {BUF_SEL, line_base + ADDR_W'(h >> SCALE_SHIFT)};
  end

  // Buffer flips on the last cycle of a frame so the first address of the next frame already uses it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      BUF_SEL  <= 1'b0;
      pending  <= 1'b0;
      SWAP_ACK <= 1'b0;
    end else begin
      SWAP_ACK <= 1'b0;
      if (frame_end && (pending || SWAP_REQ)) begin
        BUF_SEL  <= ~BUF_SEL;
        SWAP_ACK <= 1'b1;
        pending  <= 1'b0;
      end else if (SWAP_REQ) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      act_p <= '0;
      hs_p  <= {D{~H_POL}};
      vs_p  <= {D{~V_POL}};
      fs_p  <= '0;
    end else begin
      act_p <= {act_p[D-2:0], active};
      hs_p  <= {hs_p[D-2:0], hs};
      vs_p  <= {vs_p[D-2:0], vs};
      fs_p  <= {fs_p[D-2:0], fs};
    end
  end

`ifdef VGA_TESTPAT_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int RW    = (PIX_W + 2) / 3;
  localparam int GW    = (PIX_W + 1) / 3;
  localparam int BW    = PIX_W / 3;

  logic [2:0] bar_k;
  logic [2:0] bar_p [D-1];
  logic [2:0] bar_out;

  assign bar_k   = 3'(h / HW'(BAR_W));
  assign bar_out = bar_p[D-2];

  // Bar index rides the same delay as the RAM read so bars line up with DE exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < D - 1; i++) bar_p[i] <= '0;
    end else begin
      bar_p[0] <= bar_k;
      for (int i = 1; i < D - 1; i++) bar_p[i] <= bar_p[i-1];
    end
  end

  assign pix_src = TESTPAT ? {{RW{bar_out[2]}}, {GW{bar_out[1]}}, {BW{bar_out[0]}}} : RD_DATA;
`else
  assign pix_src = RD_DATA;
`endif

  always_ff @(posedge CLK) begin
    if (RST) PIXEL <= '0;
    else     PIXEL <= act_p[D-2] ? pix_src : '0;
  end

  assign HSYNC       = hs_p[D-1];
  assign VSYNC       = vs_p[D-1];
  assign DE          = act_p[D-1];
  assign FRAME_START = fs_p[D-1];

endmodule

// File: tb/tb_vga_scan_engine.sv
// tb/tb_vga_scan_engine.sv - directed vector bench for vga_scan_engine (default and reduced timing)
module tb_vga_scan_engine;

  typedef struct {
    int cyc;
    bit de, hs, vs, fs;
    int pix;
    bit ca;
    int addr;
    bit ack, bsel;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: default 800x600 timing, RD_LAT=1
  logic        rst_a, swap_a, ack_a, buf_a, hs_a, vs_a, de_a, fs_a;
  logic [14:0] addr_a;
  logic [7:0]  rd_a, pix_a;
  int          cyc_a;
`ifdef VGA_TESTPAT_EN
  logic        testpat_a;
`endif

  vga_scan_engine dut_a (
    .CLK(clk), .RST(rst_a), .SWAP_REQ(swap_a),
`ifdef VGA_TESTPAT_EN
    .TESTPAT(testpat_a),
`endif
    .RD_DATA(rd_a), .SWAP_ACK(ack_a), .BUF_SEL(buf_a), .RD_ADDR(addr_a),
    .HSYNC(hs_a), .VSYNC(vs_a), .DE(de_a), .PIXEL(pix_a), .FRAME_START(fs_a)
  );

  always @(posedge clk) rd_a <= addr_a[7:0];
  always @(posedge clk) cyc_a <= rst_a ? 0 : cyc_a + 1;

  // Instance B: 64x32 active, 80x38 total, active-low hsync, RD_LAT=3
  logic        rst_b, swap_b, ack_b, buf_b, hs_b, vs_b, de_b, fs_b;
  logic [6:0]  addr_b;
  logic [7:0]  r1_b, r2_b, rd_b, pix_b;
  int          cyc_b;
  int          phase = 0;

  vga_scan_engine #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(32), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b0), .V_POL(1'b1), .SCALE_SHIFT(3), .PIX_W(8), .RD_LAT(3), .ADDR_W(6)
  ) dut_b (
    .CLK(clk), .RST(rst_b), .SWAP_REQ(swap_b),
`ifdef VGA_TESTPAT_EN
    .TESTPAT(1'b0),
`endif
    .RD_DATA(rd_b), .SWAP_ACK(ack_b), .BUF_SEL(buf_b), .RD_ADDR(addr_b),
    .HSYNC(hs_b), .VSYNC(vs_b), .DE(de_b), .PIXEL(pix_b), .FRAME_START(fs_b)
  );

  always @(posedge clk) begin
    r1_b <= {1'b0, addr_b};
    r2_b <= r1_b;
    rd_b <= r2_b;
  end
  always @(posedge clk) cyc_b <= rst_b ? 0 : cyc_b + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int c, bit de, bit hs, bit vs, bit fs, int pix,
                              bit ca, int addr, bit ack, bit bsel);
    vec_t r;
    r.cyc = c; r.de = de; r.hs = hs; r.vs = vs; r.fs = fs; r.pix = pix;
    r.ca = ca; r.addr = addr; r.ack = ack; r.bsel = bsel;
    return r;
  endfunction

  task automatic check_row(input string tag, input vec_t r, input logic de, input logic hs,
                           input logic vs, input logic fs, input logic [7:0] pix,
                           input logic [31:0] addr, input logic ack, input logic bsel);
    chk({tag, ".de"},   32'(de),   32'(r.de));
    chk({tag, ".hs"},   32'(hs),   32'(r.hs));
    chk({tag, ".vs"},   32'(vs),   32'(r.vs));
    chk({tag, ".fs"},   32'(fs),   32'(r.fs));
    chk({tag, ".pix"},  32'(pix),  r.pix);
    chk({tag, ".ack"},  32'(ack),  32'(r.ack));
    chk({tag, ".bsel"}, 32'(bsel), 32'(r.bsel));
    if (r.ca) chk({tag, ".addr"}, addr, r.addr);
  endtask

  task automatic wait_a(input int k);
    while (cyc_a < k) @(negedge clk);
  endtask

  task automatic wait_b(input int k);
    while (cyc_b < k) @(negedge clk);
  endtask

  task automatic row_a(input vec_t r);
    check_row($sformatf("a@%0d", r.cyc), r, de_a, hs_a, vs_a, fs_a, pix_a,
              32'(addr_a), ack_a, buf_a);
  endtask

  task automatic row_b(input string tag, input vec_t r);
    check_row(tag, r, de_b, hs_b, vs_b, fs_b, pix_b, 32'(addr_b), ack_b, buf_b);
  endtask

  task automatic run_a();
    vec_t va[$];
    int   xs [9];
    int   ex [9];
    va.push_back(mk(2,    0,0,0,0, 8'h00, 1, 0,   0,0));
    va.push_back(mk(3,    1,0,0,1, 8'h00, 1, 0,   0,0));
    va.push_back(mk(4,    1,0,0,0, 8'h00, 1, 0,   0,0));
    va.push_back(mk(11,   1,0,0,0, 8'h01, 1, 1,   0,0));
    va.push_back(mk(802,  1,0,0,0, 8'h63, 0, 0,   0,0));
    va.push_back(mk(803,  0,0,0,0, 8'h00, 0, 0,   0,0));
    va.push_back(mk(826,  0,0,0,0, 8'h00, 0, 0,   0,0));
    va.push_back(mk(827,  0,1,0,0, 8'h00, 0, 0,   0,0));
    va.push_back(mk(898,  0,1,0,0, 8'h00, 0, 0,   0,0));
    va.push_back(mk(899,  0,0,0,0, 8'h00, 0, 0,   0,0));
    va.push_back(mk(1027, 1,0,0,0, 8'h00, 0, 0,   0,0));
    va.push_back(mk(8195, 1,0,0,0, 8'h64, 0, 0,   0,0));
    va.push_back(mk(8201, 1,0,0,0, 8'h64, 1, 101, 0,0));
    va.push_back(mk(8203, 1,0,0,0, 8'h65, 1, 101, 0,0));
    foreach (va[i]) begin
      wait_a(va[i].cyc);
      row_a(va[i]);
    end
    xs = '{0, 99, 100, 199, 200, 400, 700, 799, 800};
    ex = '{0, 0, 'h03, 'h03, 'h1C, 'hE0, 'hFF, 'hFF, 0};
`ifdef VGA_TESTPAT_EN
    testpat_a = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_a(10 * 1024 + 3 + xs[i]);
      chk($sformatf("a.bar x=%0d", xs[i]), 32'(pix_a), ex[i]);
    end
`else
    // Without the pattern source, line 10 shows RAM data: addr (v>>3)*100 + (x>>3)
    for (int i = 0; i < 9; i++) begin
      wait_a(10 * 1024 + 3 + xs[i]);
      chk($sformatf("a.ram x=%0d", xs[i]), 32'(pix_a),
          (xs[i] < 800) ? ((100 + xs[i] / 8) & 'hFF) : 0);
    end
`endif
  endtask

  task automatic run_b();
    vec_t vb[$];
    vb.push_back(mk(4,    0,1,0,0, 0,    1, 0,  0,0));
    vb.push_back(mk(5,    1,1,0,1, 0,    1, 0,  0,0));
    vb.push_back(mk(13,   1,1,0,0, 1,    1, 1,  0,0));
    vb.push_back(mk(68,   1,1,0,0, 7,    0, 0,  0,0));
    vb.push_back(mk(69,   0,1,0,0, 0,    0, 0,  0,0));
    vb.push_back(mk(72,   0,1,0,0, 0,    0, 0,  0,0));
    vb.push_back(mk(73,   0,0,0,0, 0,    0, 0,  0,0));
    vb.push_back(mk(80,   0,0,0,0, 0,    0, 0,  0,0));
    vb.push_back(mk(81,   0,1,0,0, 0,    0, 0,  0,0));
    vb.push_back(mk(645,  1,1,0,0, 8,    0, 0,  0,0));
    vb.push_back(mk(649,  1,1,0,0, 8,    1, 9,  0,0));
    vb.push_back(mk(653,  1,1,0,0, 9,    1, 9,  0,0));
    vb.push_back(mk(2544, 1,1,0,0, 31,   1, 31, 0,0));
    vb.push_back(mk(2548, 1,1,0,0, 31,   0, 0,  0,0));
    vb.push_back(mk(2565, 0,1,0,0, 0,    0, 0,  0,0));
    vb.push_back(mk(2644, 0,1,0,0, 0,    0, 0,  0,0));
    vb.push_back(mk(2645, 0,1,1,0, 0,    0, 0,  0,0));
    vb.push_back(mk(2804, 0,1,1,0, 0,    0, 0,  0,0));
    vb.push_back(mk(2805, 0,1,0,0, 0,    0, 0,  0,0));
    vb.push_back(mk(3039, 0,0,0,0, 0,    0, 0,  0,0));
    vb.push_back(mk(3040, 0,0,0,0, 0,    0, 0,  1,1));
    vb.push_back(mk(3041, 0,1,0,0, 0,    1, 64, 0,1));
    vb.push_back(mk(3044, 0,1,0,0, 0,    0, 0,  0,1));
    vb.push_back(mk(3045, 1,1,0,1, 'h40, 0, 0,  0,1));
    vb.push_back(mk(6080, 0,0,0,0, 0,    0, 0,  1,0));
    vb.push_back(mk(6081, 0,1,0,0, 0,    1, 0,  0,0));
    vb.push_back(mk(6085, 1,1,0,1, 0,    0, 0,  0,0));
    vb.push_back(mk(9120, 0,0,0,0, 0,    0, 0,  1,1));
    vb.push_back(mk(9125, 1,1,0,1, 'h40, 0, 0,  0,1));
    foreach (vb[i]) begin
      wait_b(vb[i].cyc);
      row_b($sformatf("b@%0d", vb[i].cyc), vb[i]);
    end
    // Reset at counter (32,16) of frame 3 while buffer 1 is selected and a swap is pending
    wait_b(10432);
    rst_b = 1'b1;
    @(negedge clk);
    row_b("b.midreset", mk(0, 0,1,0,0, 0, 1, 0, 0,0));
    rst_b = 1'b0;
    phase = 1;
    wait_b(5);
    row_b("b.restart", mk(5, 1,1,0,1, 0, 1, 0, 0,0));
    wait_b(3040);
    row_b("b.nopend", mk(3040, 0,0,0,0, 0, 0, 0, 0,0));
    wait_b(3046);
  endtask

  // Swap requests for instance B: mid-frame 0, exactly on the frame-1 boundary, mid-frame 2, mid-frame 3
  initial begin
    swap_b = 1'b0;
    forever begin
      @(negedge clk);
      swap_b = (phase == 0) && !rst_b &&
               (cyc_b == 1000 || cyc_b == 6079 || cyc_b == 6500 || cyc_b == 10000);
    end
  end

  int de_cnt = 0;
  int oob    = 0;
  int ack_log[$];
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        if (phase == 0 && cyc_b >= 5 && cyc_b < 3045 && de_b) de_cnt++;
        if (de_b && pix_b[5:0] > 6'd31) oob++;
        if (ack_b) ack_log.push_back(phase * 100000 + cyc_b);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ack [3];
    rst_a = 1'b1; rst_b = 1'b1; swap_a = 1'b0;
`ifdef VGA_TESTPAT_EN
    testpat_a = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_row("a.reset", mk(0, 0,0,0,0, 0, 1, 0, 0,0), de_a, hs_a, vs_a, fs_a, pix_a,
              32'(addr_a), ack_a, buf_a);
    row_b("b.reset", mk(0, 0,1,0,0, 0, 1, 0, 0,0));
    rst_a = 1'b0; rst_b = 1'b0;
    fork
      run_a();
      run_b();
    join
    exp_ack = '{3040, 6080, 9120};
    chk("b.de_count", de_cnt, 2048);
    chk("b.addr_range", oob, 0);
    chk("b.ack_count", ack_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < ack_log.size()) chk($sformatf("b.ack_cycle%0d", i), ack_log[i], exp_ack[i]);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
